// File: rtl/i2c_log_scheduler.sv
// Round-robin scheduler feeding one I2C frame logger from NUM_CH newest-sample slots.
// Strobe 2 clks after req_valid when idle; no backpressure to sources, overwritten samples are counted.
module i2c_log_scheduler #(
   parameter int NUM_CH       = 4,
   parameter int MIN_GAP      = 27000,
   parameter int BUSY_TIMEOUT = 8192
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      enable,
   input  logic [NUM_CH-1:0]         req_valid,
   input  logic [NUM_CH*8-1:0]       req_page,
   input  logic [NUM_CH*16-1:0]      req_value,
   input  logic                      clr_status,
   input  logic                      log_busy,
   output logic                      log_new_sample,
   output logic [7:0]                log_page,
   output logic [15:0]               log_value,
   output logic [$clog2(NUM_CH)-1:0] grant_ch,
   output logic                      sched_busy,
   output logic [NUM_CH-1:0]         ovf_flags,
   output logic                      timeout_err,
   output logic [15:0]               drop_cnt,
   output logic [15:0]               sent_cnt
);

   localparam int CW      = $clog2(NUM_CH);
   localparam int CNT_MAX = (MIN_GAP > BUSY_TIMEOUT) ? MIN_GAP : BUSY_TIMEOUT;
   localparam int CNTW    = $clog2(CNT_MAX + 1);
   localparam logic [CNTW-1:0] TO_LAST  = CNTW'(BUSY_TIMEOUT - 1);
   localparam logic [CNTW-1:0] GAP_LAST = (MIN_GAP > 0) ? CNTW'(MIN_GAP - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;

   state_t            state, state_nxt;
   logic [CNTW-1:0]   cnt, cnt_nxt;
   logic [NUM_CH-1:0] pend;
   logic [7:0]        slot_page  [NUM_CH];
   logic [15:0]       slot_value [NUM_CH];
   logic [CW-1:0]     last_grant;
   logic [CW-1:0]     pick;
   logic              pick_vld;
   logic              grant;
   logic              to_set;
   logic [NUM_CH-1:0] grant_mask;
   logic [NUM_CH-1:0] ovf_set;
   logic [3:0]        n_drop;
   logic [16:0]       drop_sum;
   logic [15:0]       drop_nxt;

   // first pending channel after the last one served
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         if (!pick_vld && pend[(int'(last_grant) + k) % NUM_CH]) begin
            pick     = CW'((int'(last_grant) + k) % NUM_CH);
            pick_vld = 1'b1;
         end
      end
   end

   assign grant = (state == S_IDLE) && enable && pick_vld && !log_busy;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      to_set    = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (grant) state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            cnt_nxt = cnt + 1'b1;
            if (log_busy) begin
               state_nxt = S_WAIT_DONE;
               cnt_nxt   = '0;
            end else if (cnt == TO_LAST) begin
               to_set    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = (MIN_GAP == 0) ? S_IDLE : S_GAP;
            end
         end
         S_WAIT_DONE: begin
            cnt_nxt = '0;
            if (!log_busy) state_nxt = (MIN_GAP == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // a sample arriving in its own grant clk replaces nothing that is lost
   always_comb begin
      grant_mask = '0;
      if (grant) grant_mask[pick] = 1'b1;
      ovf_set = req_valid & pend & ~grant_mask;
      n_drop  = '0;
      for (int i = 0; i < NUM_CH; i++) n_drop = n_drop + 4'(ovf_set[i]);
      drop_sum = {1'b0, (clr_status ? 16'h0000 : drop_cnt)} + 17'(n_drop);
      drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= S_IDLE;
         cnt            <= '0;
         pend           <= '0;
         last_grant     <= CW'(NUM_CH - 1);
         log_new_sample <= 1'b0;
         log_page       <= '0;
         log_value      <= '0;
         grant_ch       <= '0;
         sched_busy     <= 1'b0;
         ovf_flags      <= '0;
         timeout_err    <= 1'b0;
         drop_cnt       <= '0;
         sent_cnt       <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            slot_page[i]  <= '0;
            slot_value[i] <= '0;
         end
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         sched_busy     <= (state_nxt != S_IDLE);
         log_new_sample <= grant;
         if (grant) begin
            log_page   <= slot_page[pick];
            log_value  <= slot_value[pick];
            grant_ch   <= pick;
            last_grant <= pick;
            sent_cnt   <= sent_cnt + 16'd1;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (req_valid[i]) begin
               slot_page[i]  <= req_page[8*i +: 8];
               slot_value[i] <= req_value[16*i +: 16];
            end
         end
         pend        <= (pend & ~grant_mask) | req_valid;
         ovf_flags   <= (clr_status ? '0 : ovf_flags) | ovf_set;
         timeout_err <= (timeout_err & ~clr_status) | to_set;
         drop_cnt    <= drop_nxt;
      end
   end

endmodule

// File: tb/tb_i2c_log_scheduler.sv
// Bench for i2c_log_scheduler: directed scenarios plus random traffic against a timing/queue model.
module tb_i2c_log_scheduler;

   localparam int NUM_CH       = 4;
   localparam int MIN_GAP      = 20;
   localparam int BUSY_TIMEOUT = 64;

   logic                    clk = 1'b0;
   logic                    resetn = 1'b0;
   logic                    enable = 1'b0;
   logic [NUM_CH-1:0]       req_valid = '0;
   logic [NUM_CH*8-1:0]     req_page = '0;
   logic [NUM_CH*16-1:0]    req_value = '0;
   logic                    clr_status = 1'b0;
   logic                    log_busy = 1'b0;
   logic                    log_new_sample;
   logic [7:0]              log_page;
   logic [15:0]             log_value;
   logic [1:0]              grant_ch;
   logic                    sched_busy;
   logic [NUM_CH-1:0]       ovf_flags;
   logic                    timeout_err;
   logic [15:0]             drop_cnt;
   logic [15:0]             sent_cnt;

   always #5 clk = ~clk;

   i2c_log_scheduler #(.NUM_CH(NUM_CH), .MIN_GAP(MIN_GAP), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .req_valid(req_valid),
      .req_page(req_page), .req_value(req_value), .clr_status(clr_status),
      .log_busy(log_busy), .log_new_sample(log_new_sample), .log_page(log_page),
      .log_value(log_value), .grant_ch(grant_ch), .sched_busy(sched_busy),
      .ovf_flags(ovf_flags), .timeout_err(timeout_err), .drop_cnt(drop_cnt),
      .sent_cnt(sent_cnt)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: newest-sample slots, round-robin pointer, frame/gap timestamps in edges
   bit           m_pend [NUM_CH];
   logic [7:0]   m_page [NUM_CH];
   logic [15:0]  m_val  [NUM_CH];
   int           m_last, m_gch, m_drop, m_sent;
   bit           m_strobe, m_to, m_inframe, m_busy_seen;
   logic [7:0]   m_lpage;
   logic [15:0]  m_lval;
   logic [NUM_CH-1:0] m_ovf;
   int           m_gedge, m_free, m_e = 0;

   int strobes = 0;
   int gq[$];

   bit tie0 = 0;
   int lg_st = 0, lg_cnt = 0;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_pend[i] = 0; m_page[i] = '0; m_val[i] = '0;
      end
      m_last = NUM_CH - 1; m_gch = 0; m_drop = 0; m_sent = 0;
      m_strobe = 0; m_to = 0; m_inframe = 0; m_busy_seen = 0;
      m_lpage = '0; m_lval = '0; m_ovf = '0; m_gedge = 0; m_free = 0;
   endtask

   function automatic bit m_pick(output int ch);
      ch = 0;
      if (m_inframe || (m_e + 1) < m_free || !enable || log_busy) return 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         int c = (m_last + k) % NUM_CH;
         if (m_pend[c]) begin
            ch = c;
            return 1;
         end
      end
      return 0;
   endfunction

   task automatic model_edge();
      int ch, nd;
      bit g, to_set;
      logic [NUM_CH-1:0] oset;
      if (!resetn) begin
         m_e++;
         model_reset();
         return;
      end
      g = m_pick(ch);
      m_e++;
      to_set = 0;
      if (m_inframe) begin
         if (!m_busy_seen) begin
            if (log_busy) m_busy_seen = 1;
            else if (m_e == m_gedge + BUSY_TIMEOUT) begin
               to_set = 1; m_inframe = 0; m_free = m_e + MIN_GAP + 1;
            end
         end else if (!log_busy) begin
            m_inframe = 0; m_free = m_e + MIN_GAP + 1;
         end
      end
      m_strobe = g;
      if (g) begin
         m_lpage = m_page[ch]; m_lval = m_val[ch]; m_gch = ch; m_last = ch;
         m_sent = (m_sent + 1) % 65536; m_pend[ch] = 0;
         m_inframe = 1; m_busy_seen = 0; m_gedge = m_e;
      end
      oset = '0; nd = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (req_valid[i]) begin
            if (m_pend[i]) begin oset[i] = 1'b1; nd++; end
            m_page[i] = req_page[8*i +: 8];
            m_val[i]  = req_value[16*i +: 16];
            m_pend[i] = 1;
         end
      end
      if (clr_status) begin m_ovf = '0; m_to = 0; m_drop = 0; end
      m_ovf  = m_ovf | oset;
      m_to   = m_to | to_set;
      m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
   endtask

   task automatic logger();
      if (tie0) begin
         log_busy = 1'b0; lg_st = 0;
         return;
      end
      case (lg_st)
         0: if (log_new_sample) begin lg_cnt = $urandom_range(1, 8); lg_st = 1; end
         1: begin
            lg_cnt--;
            if (lg_cnt == 0) begin log_busy = 1'b1; lg_cnt = $urandom_range(3, 30); lg_st = 2; end
         end
         default: begin
            lg_cnt--;
            if (lg_cnt == 0) begin log_busy = 1'b0; lg_st = 0; end
         end
      endcase
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_eq("strobe", 32'(log_new_sample), 32'(m_strobe));
      check_eq("page", 32'(log_page), 32'(m_lpage));
      check_eq("value", 32'(log_value), 32'(m_lval));
      check_eq("grant_ch", 32'(grant_ch), 32'(m_gch));
      check_eq("sched_busy", 32'(sched_busy), 32'(m_inframe || (m_e < m_free - 1)));
      check_eq("ovf_flags", 32'(ovf_flags), 32'(m_ovf));
      check_eq("timeout_err", 32'(timeout_err), 32'(m_to));
      check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check_eq("sent_cnt", 32'(sent_cnt), 32'(m_sent));
      if (log_new_sample) begin
         strobes++;
         gq.push_back(int'(grant_ch));
      end
      logger();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic set_req(input int ch, input logic [7:0] pg, input logic [15:0] v);
      req_valid[ch]          = 1'b1;
      req_page[8*ch +: 8]    = pg;
      req_value[16*ch +: 16] = v;
   endtask

   task automatic pulse_clr();
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      log_busy = 1'b0; lg_st = 0;
      step(); step();
      resetn = 1'b1;
   endtask

   task automatic wait_busy(input string tag);
      for (int i = 0; i < 20 && !log_busy; i++) step();
      check_eq(tag, 32'(log_busy), 32'd1);
   endtask

   initial begin
      int s0, ch;
      bit inj;
      model_reset();
      step(); step();
      check_eq("rst_sent", 32'(sent_cnt), 32'd0);
      check_eq("rst_grant", 32'(grant_ch), 32'd0);
      check_eq("rst_busy", 32'(sched_busy), 32'd0);
      resetn = 1'b1;
      enable = 1'b1;
      step();

      // single sample on ch2
      set_req(2, 8'h11, 16'hBEEF);
      step();
      req_valid = '0;
      run(80);
      check_eq("t1_strobes", 32'(strobes), 32'd1);
      check_eq("t1_page", 32'(log_page), 32'h11);
      check_eq("t1_value", 32'(log_value), 32'hBEEF);
      check_eq("t1_grant", 32'(grant_ch), 32'd2);
      check_eq("t1_sent", 32'(sent_cnt), 32'd1);

      // all channels at once, from reset pointer
      do_reset();
      gq.delete();
      for (int i = 0; i < NUM_CH; i++) set_req(i, 8'(8'h20 + i), 16'(16'hA000 + i));
      step();
      req_valid = '0;
      run(4 * 80);
      check_eq("t2_ngrants", 32'(gq.size()), 32'd4);
      for (int i = 0; i < gq.size() && i < 4; i++) check_eq("t2_order", 32'(gq[i]), 32'(i));
      check_eq("t2_ovf", 32'(ovf_flags), 32'd0);
      check_eq("t2_sent", 32'(sent_cnt), 32'd4);

      // ch1 overwritten while the logger is busy
      set_req(0, 8'h30, 16'h0A0A);
      step();
      req_valid = '0;
      wait_busy("t3_busy");
      set_req(1, 8'h31, 16'h1111); step();
      set_req(1, 8'h32, 16'h2222); step();
      set_req(1, 8'h33, 16'h3333); step();
      req_valid = '0;
      check_eq("t3_ovf", 32'(ovf_flags), 32'b0010);
      check_eq("t3_drop", 32'(drop_cnt), 32'd2);
      run(80);
      check_eq("t3_value", 32'(log_value), 32'h3333);
      check_eq("t3_grant", 32'(grant_ch), 32'd1);
      pulse_clr();
      check_eq("t3_clr_ovf", 32'(ovf_flags), 32'd0);
      check_eq("t3_clr_drop", 32'(drop_cnt), 32'd0);

      // logger never answers
      tie0 = 1;
      s0 = int'(sent_cnt);
      set_req(2, 8'h42, 16'h4242);
      set_req(3, 8'h43, 16'h4343);
      step();
      req_valid = '0;
      run(2 * (BUSY_TIMEOUT + MIN_GAP) + 20);
      check_eq("t4_timeout", 32'(timeout_err), 32'd1);
      check_eq("t4_grant", 32'(grant_ch), 32'd3);
      check_eq("t4_sent", 32'(sent_cnt), 32'((s0 + 2) % 65536));
      tie0 = 0;
      pulse_clr();
      check_eq("t4_clr", 32'(timeout_err), 32'd0);

      // enable gating
      enable = 1'b0;
      s0 = strobes;
      set_req(0, 8'h50, 16'h5050);
      step();
      req_valid = '0;
      run(30);
      check_eq("t5_gated", 32'(strobes - s0), 32'd0);
      enable = 1'b1;
      step(); step();
      check_eq("t5_strobe", 32'(strobes - s0), 32'd1);
      run(80);

      // reset while waiting for the logger to finish
      set_req(1, 8'h51, 16'h5151);
      set_req(2, 8'h52, 16'h5252);
      step();
      req_valid = '0;
      wait_busy("t5_busy");
      step();
      #2 resetn = 1'b0;
      #1;
      check_eq("t5_rst_strobe", 32'(log_new_sample), 32'd0);
      check_eq("t5_rst_page", 32'(log_page), 32'd0);
      check_eq("t5_rst_value", 32'(log_value), 32'd0);
      check_eq("t5_rst_grant", 32'(grant_ch), 32'd0);
      check_eq("t5_rst_busy", 32'(sched_busy), 32'd0);
      check_eq("t5_rst_ovf", 32'(ovf_flags), 32'd0);
      check_eq("t5_rst_to", 32'(timeout_err), 32'd0);
      check_eq("t5_rst_drop", 32'(drop_cnt), 32'd0);
      check_eq("t5_rst_sent", 32'(sent_cnt), 32'd0);
      model_reset();
      log_busy = 1'b0; lg_st = 0;
      step(); step();
      resetn = 1'b1;
      run(50);
      check_eq("t5_lost", 32'(sent_cnt), 32'd0);

      // new sample in the grant clk of ch3
      set_req(0, 8'h60, 16'h00A0);
      set_req(3, 8'h63, 16'h3333);
      step();
      req_valid = '0;
      inj = 0;
      for (int i = 0; i < 200 && !inj; i++) begin
         if (m_pick(ch) && ch == 3) begin
            set_req(3, 8'h64, 16'h4444);
            inj = 1;
         end
         step();
         req_valid = '0;
      end
      check_eq("t6_inject", 32'(inj), 32'd1);
      check_eq("t6_old_value", 32'(log_value), 32'h3333);
      check_eq("t6_old_grant", 32'(grant_ch), 32'd3);
      run(120);
      check_eq("t6_new_value", 32'(log_value), 32'h4444);
      check_eq("t6_drop", 32'(drop_cnt), 32'd0);
      check_eq("t6_ovf", 32'(ovf_flags), 32'd0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(0, 19) == 0) set_req(i, 8'($urandom), 16'($urandom));
         enable     = ($urandom_range(0, 49) != 0);
         clr_status = ($urandom_range(0, 299) == 0);
         step();
         req_valid  = '0;
         clr_status = 1'b0;
      end
      enable = 1'b1;
      run(100);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
